// File: rtl/output_deskew_collector_pkg.sv
// output_deskew_collector_pkg: shared geometry for the post-array output path
package output_deskew_collector_pkg;
  localparam int ARRAYWIDTH = 4;
  localparam int OUTPUT_BUF_DATASIZE = 32;
  localparam int OUT_FIFO_DEPTH = 8;
  localparam int ROW_CNT_W = 16;
endpackage

// File: rtl/output_deskew_collector_if.sv
// output_deskew_collector_if: skewed column input and row output handshake
interface output_deskew_collector_if #(
  parameter int W = output_deskew_collector_pkg::ARRAYWIDTH,
  parameter int DS = output_deskew_collector_pkg::OUTPUT_BUF_DATASIZE
);
  logic [W-1:0] col_valid;
  logic [W*DS-1:0] col_data;
  logic out_valid;
  logic out_ready;
  logic [W*DS-1:0] out_data;
  modport master (output col_valid, col_data, out_ready, input out_valid, out_data);
  modport slave (input col_valid, col_data, out_ready, output out_valid, out_data);
endinterface

// File: rtl/output_deskew_collector_deskew_lane.sv
// deskew_lane: fixed-delay valid/data shift register for one array column
module deskew_lane #(
  parameter int DELAY = 0,
  parameter int DS = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic [DS-1:0] in_data,
  output logic out_valid,
  output logic [DS-1:0] out_data
);
  if (DELAY == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk | rst;
    assign out_valid = in_valid;
    assign out_data = in_data;
  end else begin : g_pipe
    logic [DELAY-1:0] vp;
    logic [DS-1:0] dp [DELAY];
    always_ff @(posedge clk or posedge rst)
      if (rst) vp <= '0;
      else vp <= DELAY'({vp, in_valid});
    // data stages need no reset: only the valid pipe qualifies them
    always_ff @(posedge clk) begin
      dp[0] <= in_data;
      for (int k = 1; k < DELAY; k++) dp[k] <= dp[k-1];
    end
    assign out_valid = vp[DELAY-1];
    assign out_data = dp[DELAY-1];
  end
endmodule

// File: rtl/output_deskew_collector.sv
// output_deskew_collector: realigns skewed array columns into rows, buffers them, counts frame rows
module output_deskew_collector
  import output_deskew_collector_pkg::*;
#(
  parameter int W = ARRAYWIDTH,
  parameter int DS = OUTPUT_BUF_DATASIZE,
  parameter int DEPTH = OUT_FIFO_DEPTH,
  parameter int RW = ROW_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [RW-1:0] cfg_rows,
  output_deskew_collector_if.slave bus,
  output logic busy,
  output logic frame_done,
  output logic err_ovf,
  output logic err_skew
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  logic [1:0] state, state_nxt;
  logic [W-1:0] av;
  logic [W*DS-1:0] ad;
  logic [W*DS-1:0] mem [DEPTH];
  logic [AW:0] wr, rd;
  logic [RW-1:0] cfg_q, in_cnt, out_cnt, in_cnt_nxt, out_cnt_nxt;
  logic row, collecting, empty, full, push_req, push, pop, drop, skew_evt, start_ok;
  for (genvar i = 0; i < W; i++) begin : g_lane
    deskew_lane #(.DELAY(W-1-i), .DS(DS)) u_lane (
      .clk(clk),
      .rst(rst),
      .in_valid(bus.col_valid[i]),
      .in_data(bus.col_data[i*DS +: DS]),
      .out_valid(av[i]),
      .out_data(ad[i*DS +: DS])
    );
  end
  assign row = &av;
  assign collecting = state == COLLECT;
  assign empty = wr == rd;
  assign full = (wr ^ rd) == {1'b1, {AW{1'b0}}};
  assign pop = !empty && bus.out_ready;
  assign push_req = row && collecting;
  assign drop = push_req && full && !pop;
  assign push = push_req && !drop;
  assign skew_evt = (|av && !row) || (row && !collecting);
  assign start_ok = start && state == IDLE;
  // dropped rows are counted as consumed so the frame can still terminate
  assign in_cnt_nxt = in_cnt + RW'(push_req);
  assign out_cnt_nxt = out_cnt + RW'(pop || drop);
  assign bus.out_valid = !empty;
  assign bus.out_data = empty ? '0 : mem[rd[AW-1:0]];
  assign busy = state != IDLE;
  assign frame_done = state == DONE;
  always_comb
    state_nxt = state == IDLE    ? (start ? (cfg_rows == '0 ? DONE : COLLECT) : IDLE) :
                state == COLLECT ? (push_req && in_cnt_nxt == cfg_q ? DRAIN : COLLECT) :
                state == DRAIN   ? (out_cnt_nxt == cfg_q ? DONE : DRAIN) : IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      wr <= '0;
      rd <= '0;
      cfg_q <= '0;
      in_cnt <= '0;
      out_cnt <= '0;
      err_ovf <= 1'b0;
      err_skew <= 1'b0;
    end else begin
      state <= state_nxt;
      wr <= wr + (AW+1)'(push);
      rd <= rd + (AW+1)'(pop);
      cfg_q <= start_ok ? cfg_rows : cfg_q;
      in_cnt <= start_ok ? '0 : in_cnt_nxt;
      out_cnt <= start_ok ? '0 : out_cnt_nxt;
      err_ovf <= (err_ovf && !start_ok) || drop;
      err_skew <= (err_skew && !start_ok) || skew_evt;
    end
  always_ff @(posedge clk)
    if (push) mem[wr[AW-1:0]] <= ad;
endmodule

// File: tb/tb_output_deskew_collector.sv
// tb_output_deskew_collector: directed and random frames checked against a queue-based row model
module tb_output_deskew_collector;
  localparam int W = 4;
  localparam int DS = 32;
  localparam int DEPTH = 4;
  localparam int RW = 16;
  localparam int M_IDLE = 0;
  localparam int M_COLLECT = 1;
  localparam int M_DRAIN = 2;
  localparam int M_DONE = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [RW-1:0] cfg_rows = '0;
  logic busy, frame_done, err_ovf, err_skew;
  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] hv[$];
  logic [W*DS-1:0] hd[$];
  logic [W*DS-1:0] mq[$];
  logic [W-1:0] fv[$];
  logic [W*DS-1:0] fd[$];
  int m_mode, m_rows, m_in, m_out;
  bit m_ovf, m_skew;
  output_deskew_collector_if #(.W(W), .DS(DS)) bus ();
  output_deskew_collector #(.W(W), .DS(DS), .DEPTH(DEPTH), .RW(RW)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .cfg_rows(cfg_rows),
    .bus(bus.slave),
    .busy(busy),
    .frame_done(frame_done),
    .err_ovf(err_ovf),
    .err_skew(err_skew)
  );
  always #5 clk = ~clk;
  function automatic logic [W*DS-1:0] rnd_row();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic chk(input string tag, input logic [W*DS-1:0] obs, input logic [W*DS-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    hv = {};
    hd = {};
    for (int i = 0; i < W; i++) begin
      hv.push_back('0);
      hd.push_back('0);
    end
    mq = {};
    m_mode = M_IDLE;
    m_rows = 0;
    m_in = 0;
    m_out = 0;
    m_ovf = 0;
    m_skew = 0;
  endtask
  // lane i of the aligned row is whatever lane i carried W-1-i cycles earlier
  task automatic model_step();
    logic [W-1:0] av;
    logic [W*DS-1:0] ar;
    bit full_row, coll, pop, acc;
    hv.push_front(bus.col_valid);
    hd.push_front(bus.col_data);
    void'(hv.pop_back());
    void'(hd.pop_back());
    for (int i = 0; i < W; i++) begin
      av[i] = hv[W-1-i][i];
      ar[i*DS +: DS] = hd[W-1-i][i*DS +: DS];
    end
    full_row = &av;
    coll = m_mode == M_COLLECT;
    pop = mq.size() > 0 && bus.out_ready;
    acc = start && m_mode == M_IDLE;
    if (acc) begin
      m_ovf = 0;
      m_skew = 0;
    end
    if ((av != '0 && !full_row) || (full_row && !coll)) m_skew = 1;
    if (pop) begin
      void'(mq.pop_front());
      m_out++;
    end
    if (full_row && coll) begin
      m_in++;
      if (mq.size() < DEPTH) mq.push_back(ar);
      else begin
        m_ovf = 1;
        m_out++;
      end
    end
    case (m_mode)
      M_IDLE: if (acc) begin
        m_rows = int'(cfg_rows);
        m_in = 0;
        m_out = 0;
        m_mode = cfg_rows == '0 ? M_DONE : M_COLLECT;
      end
      M_COLLECT: if (full_row && m_in == m_rows) m_mode = M_DRAIN;
      M_DRAIN: if (m_out == m_rows) m_mode = M_DONE;
      default: m_mode = M_IDLE;
    endcase
  endtask
  task automatic check_all();
    chk("out_valid", bus.out_valid, mq.size() > 0);
    chk("out_data", bus.out_data, mq.size() > 0 ? mq[0] : '0);
    chk("busy", busy, m_mode != M_IDLE);
    chk("frame_done", frame_done, m_mode == M_DONE);
    chk("err_ovf", err_ovf, m_ovf);
    chk("err_skew", err_skew, m_skew);
  endtask
  task automatic tick();
    bus.col_valid = fv.size() > 0 ? fv[0] : '0;
    bus.col_data = fd.size() > 0 ? fd[0] : rnd_row();
    if (rst) model_reset();
    else model_step();
    @(posedge clk);
    #1;
    if (fv.size() > 0) begin
      void'(fv.pop_front());
      void'(fd.pop_front());
    end
    start = 1'b0;
    check_all();
  endtask
  // schedules a row so that lane i is presented i cycles after lane 0
  task automatic launch(input logic [W*DS-1:0] r, input logic [W-1:0] mask);
    logic [W-1:0] v;
    logic [W*DS-1:0] d;
    while (fv.size() < W) begin
      fv.push_back('0);
      fd.push_back(rnd_row());
    end
    for (int i = 0; i < W; i++) begin
      v = fv[i];
      v[i] = mask[i];
      fv[i] = v;
      d = fd[i];
      d[i*DS +: DS] = r[i*DS +: DS];
      fd[i] = d;
    end
  endtask
  task automatic run_until_idle(input int budget);
    for (int k = 0; k < budget && (m_mode != M_IDLE || fv.size() > 0); k++) tick();
    chk("frame_end_busy", busy, 1'b0);
  endtask
  task automatic begin_frame(input int rows);
    cfg_rows = RW'(rows);
    start = 1'b1;
    tick();
  endtask
  initial begin
    logic [W*DS-1:0] r;
    bus.col_valid = '0;
    bus.col_data = '0;
    bus.out_ready = 1'b0;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    tick();
    // in-order rows with lane i of row n holding n*16+i
    bus.out_ready = 1'b1;
    begin_frame(3);
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < W; i++) r[i*DS +: DS] = DS'(n*16 + i);
      launch(r, '1);
      if (n == 1) begin
        cfg_rows = RW'(9);
        start = 1'b1;
      end
      tick();
    end
    run_until_idle(40);
    // asynchronous reset in the middle of a frame
    begin_frame(4);
    launch(rnd_row(), '1);
    tick();
    launch(rnd_row(), 4'b0111);
    tick();
    for (int k = 0; k < 3; k++) tick();
    #2 rst = 1'b1;
    #1;
    chk("async_out_valid", bus.out_valid, 1'b0);
    chk("async_out_data", bus.out_data, '0);
    chk("async_busy", busy, 1'b0);
    chk("async_err_skew", err_skew, 1'b0);
    fv = {};
    fd = {};
    tick();
    rst = 1'b0;
    tick();
    // overflow: six rows into a four-deep FIFO with the consumer stalled
    bus.out_ready = 1'b0;
    begin_frame(6);
    for (int n = 0; n < 6; n++) begin
      launch(rnd_row(), '1);
      tick();
    end
    for (int k = 0; k < W + 2; k++) tick();
    chk("ovf_sticky", err_ovf, 1'b1);
    bus.out_ready = 1'b1;
    run_until_idle(40);
    // full FIFO with a simultaneous push and pop
    bus.out_ready = 1'b0;
    begin_frame(5);
    for (int t = 0; t < 12; t++) begin
      if (t < 5) launch(rnd_row(), '1);
      bus.out_ready = t == 7;
      tick();
    end
    bus.out_ready = 1'b1;
    run_until_idle(40);
    // lane 2 withheld for one row
    begin_frame(2);
    launch(rnd_row(), 4'b1011);
    tick();
    launch(rnd_row(), '1);
    tick();
    launch(rnd_row(), '1);
    tick();
    run_until_idle(40);
    // empty frame, with a start arriving while DONE
    begin_frame(0);
    cfg_rows = RW'(3);
    start = 1'b1;
    tick();
    tick();
    // random frames with stalls, occasional broken rows and surplus rows
    for (int f = 0; f < 8; f++) begin
      begin_frame($urandom_range(1, 7));
      for (int k = 0; k < 300 && m_mode == M_COLLECT; k++) begin
        bus.out_ready = $urandom_range(0, 3) != 0;
        if ($urandom_range(0, 1) == 1) launch(rnd_row(), $urandom_range(0, 9) == 0 ? 4'b1101 : 4'b1111);
        tick();
      end
      bus.out_ready = 1'b1;
      run_until_idle(100);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
